// File: rtl/program_memory_loader.sv
// Instruction memory with a 1-cycle registered fetch port and a byte-stream program loader.
// Loader takes one byte per accepted LD_VALID/LD_READY; fetches are ignored while a load session is busy.
module program_memory_loader #(
    parameter int ADDR_W = 8,
    parameter int IM_W   = 4,
    parameter int LR_W   = 3,
    parameter int SR_W   = 3,
    parameter int OP_W   = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              FETCH_EN,
    input  logic [ADDR_W-1:0] PA,
    output logic [IM_W-1:0]   IM,
    output logic [LR_W-1:0]   LR,
    output logic [SR_W-1:0]   SR,
    output logic [OP_W-1:0]   OP,
    output logic              INSTR_VALID,
    input  logic              LD_START,
    input  logic [ADDR_W-1:0] LD_BASE,
    input  logic [7:0]        LD_DATA,
    input  logic              LD_VALID,
    input  logic              LD_LAST,
    output logic              LD_READY,
    output logic              LD_BUSY,
    output logic              LD_DONE,
    output logic              LD_ERR,
    output logic [ADDR_W:0]   LD_COUNT
);

    localparam int W = IM_W + LR_W + SR_W + OP_W;
    localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [W-1:0]        r_mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_low;
    logic                w_acc;
    logic [15:0]         w_word16;
    logic [W-1:0]        w_word;
    logic                w_pad;
    logic [ADDR_W:0]     w_cnt_next;

    assign w_acc      = LD_VALID && LD_READY;
    assign w_word16   = {LD_DATA, r_low};
    assign w_word     = w_word16[W-1:0];
    // Any bit of the high byte beyond the packed fields is a malformed word.
    assign w_pad      = |(w_word16 >> W);
    assign w_cnt_next = LD_COUNT + (ADDR_W+1)'(1);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        LD_READY = 1'b0;
        LD_BUSY  = 1'b1;
        LD_DONE  = 1'b0;
        case (r_state)
            S_IDLE: begin
                LD_BUSY = 1'b0;
                if (LD_START) w_next = S_LO;
            end
            S_LO: begin
                LD_READY = 1'b1;
                if (w_acc) w_next = LD_LAST ? S_DONE : S_HI;
            end
            S_HI: begin
                LD_READY = 1'b1;
                if (w_acc) begin
                    if (LD_LAST || (w_cnt_next == C_DEPTH)) w_next = S_DONE;
                    else                                    w_next = S_LO;
                end
            end
            S_DONE: begin
                LD_DONE = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_addr      <= '0;
            r_low       <= '0;
            LD_COUNT    <= '0;
            LD_ERR      <= 1'b0;
            IM          <= '0;
            LR          <= '0;
            SR          <= '0;
            OP          <= '0;
            INSTR_VALID <= 1'b0;
        end else begin
            INSTR_VALID <= 1'b0;
            // Fetch reads before any write of this edge, so a fetch alongside LD_START sees old contents.
            if (r_state == S_IDLE && FETCH_EN) begin
                {OP, SR, LR, IM} <= r_mem[PA];
                INSTR_VALID      <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (LD_START) begin
                        r_addr   <= LD_BASE;
                        LD_COUNT <= '0;
                        LD_ERR   <= 1'b0;
                    end
                end
                S_LO: begin
                    if (w_acc) begin
                        r_low <= LD_DATA;
                        if (LD_LAST) LD_ERR <= 1'b1;
                    end
                end
                S_HI: begin
                    if (w_acc) begin
                        r_addr   <= r_addr + ADDR_W'(1);
                        LD_COUNT <= w_cnt_next;
                        if (w_pad || (!LD_LAST && w_cnt_next == C_DEPTH)) LD_ERR <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (r_state == S_HI && w_acc) r_mem[r_addr] <= w_word;
    end

endmodule

// File: tb/tb_program_memory_loader.sv
// Randomized bench for program_memory_loader: byte-stream reference model plus directed literal checks.
module tb_program_memory_loader;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       nRST;
    logic       FETCH_EN;
    logic [7:0] PA;
    logic [3:0] IM;
    logic [2:0] LR;
    logic [2:0] SR;
    logic [4:0] OP;
    logic       INSTR_VALID;
    logic       LD_START;
    logic [7:0] LD_BASE;
    logic [7:0] LD_DATA;
    logic       LD_VALID;
    logic       LD_LAST;
    logic       LD_READY;
    logic       LD_BUSY;
    logic       LD_DONE;
    logic       LD_ERR;
    logic [8:0] LD_COUNT;

    // Small instance used for the overflow case.
    logic       s_start, s_valid;
    logic [3:0] s_base;
    logic [7:0] s_data;
    logic [3:0] s_im;
    logic [2:0] s_lr, s_sr;
    logic [4:0] s_op;
    logic       s_iv, s_ready, s_busy, s_done, s_err;
    logic [4:0] s_count;

    program_memory_loader dut (
        .CLK(CLK), .nRST(nRST), .FETCH_EN(FETCH_EN), .PA(PA),
        .IM(IM), .LR(LR), .SR(SR), .OP(OP), .INSTR_VALID(INSTR_VALID),
        .LD_START(LD_START), .LD_BASE(LD_BASE), .LD_DATA(LD_DATA),
        .LD_VALID(LD_VALID), .LD_LAST(LD_LAST), .LD_READY(LD_READY),
        .LD_BUSY(LD_BUSY), .LD_DONE(LD_DONE), .LD_ERR(LD_ERR), .LD_COUNT(LD_COUNT)
    );

    program_memory_loader #(.ADDR_W(4)) dut_small (
        .CLK(CLK), .nRST(nRST), .FETCH_EN(1'b0), .PA(4'h0),
        .IM(s_im), .LR(s_lr), .SR(s_sr), .OP(s_op), .INSTR_VALID(s_iv),
        .LD_START(s_start), .LD_BASE(s_base), .LD_DATA(s_data),
        .LD_VALID(s_valid), .LD_LAST(1'b0), .LD_READY(s_ready),
        .LD_BUSY(s_busy), .LD_DONE(s_done), .LD_ERR(s_err), .LD_COUNT(s_count)
    );

    int checks = 0;
    int errors = 0;
    bit run_cmp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] w15(input logic [7:0] lo, input logic [7:0] hi);
        logic [15:0] w;
        w = {hi, lo};
        return w[14:0];
    endfunction

    // Reference model: a session is a byte stream; even-indexed bytes are low halves,
    // each odd-indexed byte completes word (index/2) at base+index/2 modulo 256.
    logic [14:0] m_mem [256];
    bit          m_known [256];
    bit          m_acc, m_done, m_err, m_iv, m_fknown, m_idle;
    int          m_nb;
    logic [7:0]  m_base, m_low, m_a;
    logic [14:0] m_fields;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_acc = 0; m_done = 0; m_err = 0; m_iv = 0; m_nb = 0;
            m_fields = '0; m_fknown = 1;
        end else begin
            m_idle = !m_acc && !m_done;
            m_iv   = m_idle && FETCH_EN;
            if (m_iv) begin
                m_fields = m_mem[PA];
                m_fknown = m_known[PA];
            end
            if (m_done) begin
                m_done = 0;
            end else if (!m_acc) begin
                if (LD_START) begin
                    m_acc = 1; m_nb = 0; m_base = LD_BASE; m_err = 0;
                end
            end else if (LD_VALID) begin
                if (m_nb % 2 == 0) begin
                    m_low = LD_DATA;
                    m_nb++;
                    if (LD_LAST) begin m_err = 1; m_acc = 0; m_done = 1; end
                end else begin
                    m_a = m_base + 8'(m_nb / 2);
                    m_mem[m_a] = w15(m_low, LD_DATA);
                    m_known[m_a] = 1;
                    if (LD_DATA[7]) m_err = 1;
                    m_nb++;
                    if (LD_LAST) begin
                        m_acc = 0; m_done = 1;
                    end else if (m_nb / 2 == 256) begin
                        m_err = 1; m_acc = 0; m_done = 1;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (run_cmp) begin
            chk("instr_valid", INSTR_VALID, m_iv);
            if (m_fknown) chk("fields", {OP, SR, LR, IM}, m_fields);
            chk("ld_ready", LD_READY, m_acc);
            chk("ld_busy", LD_BUSY, m_acc || m_done);
            chk("ld_done", LD_DONE, m_done);
            chk("ld_err", LD_ERR, m_err);
            chk("ld_count", LD_COUNT, m_nb / 2);
        end
    end

    logic [7:0] tx[$];

    // fmode: 0 no fetch, 1 random fetches, 2 FETCH_EN held (including the LD_START cycle)
    task automatic session(input logic [7:0] base, input bit gaps, input int fmode);
        int  i, guard;
        logic rdy;
        @(posedge CLK); #1;
        LD_START = 1; LD_BASE = base;
        FETCH_EN = (fmode == 2); PA = $urandom;
        @(posedge CLK); #1;
        LD_START = 0;
        i = 0; guard = 0;
        while (i < tx.size() && guard < 4000) begin
            LD_DATA  = tx[i];
            LD_LAST  = (i == tx.size() - 1);
            LD_VALID = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (fmode == 1) FETCH_EN = 1'($urandom_range(0, 1));
            if (fmode != 0) PA = $urandom;
            @(negedge CLK); rdy = LD_READY;
            @(posedge CLK); #1;
            if (LD_VALID && rdy) i++;
            guard++;
        end
        chk("session_bytes_accepted", i, tx.size());
        LD_VALID = 0; LD_LAST = 0; FETCH_EN = 0;
        guard = 0;
        while (LD_BUSY && guard < 10) begin
            @(posedge CLK); #1;
            guard++;
        end
        chk("session_ends", LD_BUSY, 0);
    endtask

    task automatic fetch(input logic [7:0] a);
        @(posedge CLK); #1;
        FETCH_EN = 1; PA = a;
        @(posedge CLK); #1;
        FETCH_EN = 0;
    endtask

    task automatic fill_random(input int nbytes, input bit allow_pad);
        tx.delete();
        for (int k = 0; k < nbytes; k++) begin
            if (k % 2 == 1 && !(allow_pad && $urandom_range(0, 4) == 0))
                tx.push_back(8'($urandom) & 8'h7F);
            else
                tx.push_back(8'($urandom));
        end
    endtask

    initial begin
        logic [7:0] lo0, hi0, lo1, hi1;
        logic [14:0] old41;
        int acc, guard, nw;

        nRST = 1; FETCH_EN = 0; PA = 0; LD_START = 0; LD_BASE = 0;
        LD_DATA = 0; LD_VALID = 0; LD_LAST = 0;
        s_start = 0; s_valid = 0; s_base = 0; s_data = 0;
        #2 nRST = 0;
        #1 run_cmp = 1;
        @(posedge CLK); #1;
        chk("rst_count", LD_COUNT, 0);
        chk("rst_fields", {OP, SR, LR, IM}, 0);
        @(posedge CLK); #1;
        nRST = 1;

        // Basic load and fetch with hand-decoded fields.
        tx = '{8'hA5, 8'h3D};
        session(8'h10, 0, 0);
        chk("a_count", LD_COUNT, 1);
        chk("a_err", LD_ERR, 0);
        fetch(8'h10);
        chk("a_iv", INSTR_VALID, 1);
        chk("a_im", IM, 4'h5);
        chk("a_lr", LR, 3'h2);
        chk("a_sr", SR, 3'h3);
        chk("a_op", OP, 5'h0F);

        // Reset mid-session: first word persists, pending low byte is dropped.
        @(posedge CLK); #1;
        LD_START = 1; LD_BASE = 8'h20;
        @(posedge CLK); #1;
        LD_START = 0; LD_VALID = 1; LD_DATA = 8'h11;
        @(posedge CLK); #1; LD_DATA = 8'h22;
        @(posedge CLK); #1; LD_DATA = 8'h33;
        @(posedge CLK); #1;
        LD_VALID = 0;
        nRST = 0;
        #1;
        chk("rst_mid_busy", LD_BUSY, 0);
        chk("rst_mid_ready", LD_READY, 0);
        chk("rst_mid_count", LD_COUNT, 0);
        @(posedge CLK); #1;
        nRST = 1;
        fetch(8'h20);
        chk("rst_mid_word", {OP, SR, LR, IM}, 15'h2211);
        tx = '{8'h44, 8'h05};
        session(8'h21, 0, 0);
        fetch(8'h21);
        chk("rst_next_word", {OP, SR, LR, IM}, 15'h0544);

        // Wrap from 0xFF to 0x00 with random valid gaps.
        fill_random(4, 0);
        lo0 = tx[0]; hi0 = tx[1]; lo1 = tx[2]; hi1 = tx[3];
        session(8'hFF, 1, 0);
        chk("wrap_count", LD_COUNT, 2);
        chk("wrap_err", LD_ERR, 0);
        fetch(8'hFF);
        chk("wrap_ff", {OP, SR, LR, IM}, w15(lo0, hi0));
        fetch(8'h00);
        chk("wrap_00", {OP, SR, LR, IM}, w15(lo1, hi1));

        // Odd byte count: second word must not be written.
        tx = '{8'h01, 8'h02, 8'h03, 8'h04};
        session(8'h40, 0, 0);
        old41 = 15'h0403;
        tx = '{8'hAA, 8'h55, 8'hCC};
        session(8'h40, 0, 0);
        chk("odd_err", LD_ERR, 1);
        chk("odd_count", LD_COUNT, 1);
        fetch(8'h41);
        chk("odd_word_kept", {OP, SR, LR, IM}, old41);

        // Pad bit set in high byte.
        tx = '{8'h12, 8'h80};
        session(8'h50, 0, 0);
        chk("pad_err", LD_ERR, 1);
        chk("pad_count", LD_COUNT, 1);
        fetch(8'h50);
        chk("pad_word", {OP, SR, LR, IM}, 15'h0012);

        // FETCH_EN held throughout a load, including the start cycle.
        fill_random(6, 0);
        session(8'h60, 1, 2);

        // Back-to-back fetches over 0..3.
        fill_random(8, 0);
        session(8'h00, 0, 0);
        @(posedge CLK); #1;
        FETCH_EN = 1; PA = 0;
        for (int a = 1; a <= 4; a++) begin
            @(posedge CLK); #1;
            chk("b2b_iv", INSTR_VALID, 1);
            chk("b2b_word", {OP, SR, LR, IM}, w15(tx[2*(a-1)], tx[2*(a-1)+1]));
            if (a < 4) PA = 8'(a);
            else       FETCH_EN = 0;
        end

        // Randomized sessions with interleaved fetches.
        for (int n = 0; n < 30; n++) begin
            nw = $urandom_range(1, 5);
            fill_random(($urandom_range(0, 3) == 0) ? 2*nw - 1 : 2*nw, 1);
            session(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
            for (int f = 0; f < 3; f++) fetch(8'($urandom));
        end

        // Overflow on the 16-word instance: no LD_LAST, 32 bytes.
        @(posedge CLK); #1;
        s_start = 1; s_base = 4'h3;
        @(posedge CLK); #1;
        s_start = 0; s_valid = 1;
        acc = 0; guard = 0;
        while (!s_done && guard < 100) begin
            s_data = 8'($urandom) & 8'h7F;
            @(negedge CLK);
            if (s_ready) acc++;
            @(posedge CLK); #1;
            guard++;
        end
        chk("ovf_bytes", acc, 32);
        chk("ovf_done", s_done, 1);
        chk("ovf_err", s_err, 1);
        chk("ovf_count", s_count, 16);
        chk("ovf_ready_in_done", s_ready, 0);
        @(posedge CLK); #1;
        chk("ovf_ready_after", s_ready, 0);
        chk("ovf_busy_after", s_busy, 0);
        chk("ovf_done_pulse", s_done, 0);
        s_valid = 0;

        repeat (2) @(posedge CLK);
        #1 run_cmp = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
